// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline stage register with flush, saturating stall counter and optional skid buffer
// Ports: CLK/RST clock and synchronous active-high reset; flush kills held beats and any beat accepted this cycle;
//   in_valid/in_ready/in_data upstream handshake; out_valid/out_ready/out_data downstream handshake;
//   stall_cnt saturating count of cycles with out_valid & ~out_ready (cleared by RST only).
// Build option: define PIPE_STAGE_SKID_EN for a two-entry stage whose in_ready is a pure register output.
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic main_v_q, main_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic acc, main_load;
  assign acc = in_valid & in_ready;
  // main may take new content when it is empty or its beat leaves this cycle
  assign main_load = ~main_v_q | out_ready;
  assign out_valid = main_v_q;
  assign out_data = main_data_q;
  assign stall_cnt = stall_cnt_q;
  assign stall_cnt_d = (main_v_q & ~out_ready & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
`ifdef PIPE_STAGE_SKID_EN
  logic skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  // in_ready comes straight from a flop; the skid absorbs the beat accepted while main stalls
  assign in_ready = ~skid_v_q;
  always_comb begin
    main_v_d = main_load ? (skid_v_q | acc) : 1'b1;
    main_data_d = !main_load ? main_data_q : skid_v_q ? skid_data_q : acc ? in_data : main_data_q;
    skid_v_d = ~main_load & (skid_v_q | acc);
    skid_data_d = (~main_load & acc) ? in_data : skid_data_q;
  end
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      skid_v_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      skid_v_q <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  // single entry: accept only when main is empty or draining, keeping full throughput
  assign in_ready = main_load;
  always_comb begin
    main_v_d = acc | ~main_load;
    main_data_d = acc ? in_data : main_data_q;
  end
`endif
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      main_v_q <= 1'b0;
      main_data_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      main_data_q <= main_data_d;
    end
    stall_cnt_q <= RST ? '0 : stall_cnt_d;
  end
endmodule
